// File: rtl/config_loader_pkg.sv
// Shared FSM encoding and word-count helpers for the config chain loader.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int words_needed(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int last_word_bits(input int chain_len, input int word_w);
    return (chain_len % word_w == 0) ? word_w : chain_len % word_w;
  endfunction

endpackage

// File: rtl/config_rb_packer.sv
// Packs bits leaving the config chain into LSB-first words with valid/ready.
module config_rb_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              last,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              stall
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              complete;

  assign complete = last || (cnt == CW'(WORD_W - 1));
  // Hold the chain only if this shift would overwrite an unconsumed word
  assign stall = rb_valid && !rb_ready && complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (shift) begin
        if (complete) begin
          rb_data  <= acc | (WORD_W'(bit_in) << cnt);
          rb_valid <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc[cnt] <= bit_in;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Serializes bitstream words LSB-first into the config chain with a gated shift clock.
// Readback of the old chain contents is built only with CONFIG_READBACK_EN defined.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              chain_in,
  output logic              chain_clk_en,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready
);

  localparam int WORDS     = words_needed(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int BUF_W     = $clog2(WORD_W + 1);
  localparam int WL_W      = $clog2(WORDS + 1);

  localparam logic [BUF_W-1:0] FULL_CNT = BUF_W'(WORD_W);
  localparam logic [BUF_W-1:0] LAST_CNT = BUF_W'(LAST_BITS);
  localparam logic [WL_W-1:0]  WL_INIT  = WL_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BUF_W-1:0]  buf_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WL_W-1:0]   words_left;
  logic              shift;
  logic              take;
  logic              last_pos;
  logic              last_shift;
  logic              rb_stall;

  assign shift = (state == LOAD) && (buf_cnt != '0) && !rb_stall;
  // Refill may overlap the final bit of the current word
  assign in_ready = (state == LOAD) && (words_left != '0) &&
                    (buf_cnt == '0 || (buf_cnt == BUF_W'(1) && shift));
  assign take         = in_valid && in_ready;
  assign chain_clk_en = shift;
  assign chain_in     = sreg[0];
  assign last_pos     = (bit_cnt == LAST_IDX);
  assign last_shift   = shift && last_pos;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sreg       <= '0;
      buf_cnt    <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            bit_cnt    <= '0;
            buf_cnt    <= '0;
            words_left <= WL_INIT;
          end
        end
        LOAD: begin
          if (last_shift) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (shift) begin
        sreg    <= sreg >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (take) begin
        sreg       <= in_data;
        buf_cnt    <= (words_left == WL_W'(1)) ? LAST_CNT : FULL_CNT;
        words_left <= words_left - 1'b1;
      end else if (shift) begin
        buf_cnt <= buf_cnt - 1'b1;
      end
    end
  end

`ifdef CONFIG_READBACK_EN
  logic clear_rb;

  assign clear_rb = start && (state != LOAD);

  config_rb_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk      (config_clk),
    .rst      (config_reset),
    .clear    (clear_rb),
    .shift    (shift),
    .bit_in   (chain_out),
    .last     (last_pos),
    .rb_ready (rb_ready),
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
    .stall    (rb_stall)
  );
`else
  logic unused;

  assign rb_data  = '0;
  assign rb_valid = 1'b0;
  assign rb_stall = 1'b0;
  assign unused   = ^{chain_out, rb_ready};
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: chain modelled as a shift register, random words and gaps.
module tb_config_chain_loader;

  localparam int L = 40;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         chain_in;
  logic         chain_clk_en;
  logic         chain_out;
  logic         busy;
  logic         done;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         rb_ready = 1'b1;

  logic [L-1:0] chain = '0;
  logic [L-1:0] ref_img = '0;
  bit           ref_known = 1'b0;
  logic [W-1:0] rbq[$];

  int tests = 0;
  int fails = 0;

  int r_shifts, r_en_low, r_rb_seen, r_rel;
  bit r_third, r_done_ok, r_timeout, r_started_ok, r_early;

  always #5 clk = ~clk;

  assign chain_out = chain[0];
  always @(posedge clk) if (chain_clk_en) chain <= {chain_in, chain[L-1:1]};

  config_chain_loader #(
    .CHAIN_LEN (L),
    .WORD_W    (W)
  ) dut (
    .config_clk   (clk),
    .config_reset (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .chain_in     (chain_in),
    .chain_clk_en (chain_clk_en),
    .chain_out    (chain_out),
    .busy         (busy),
    .done         (done),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .rb_ready     (rb_ready)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [L-1:0] image_of(input logic [W-1:0] w0, w1);
    logic [2*W-1:0] full;
    full = {w1, w0};
    return full[L-1:0];
  endfunction

  // Host + readback consumer; rb_mode 0 ready, 1 random, 2 held low for `hold` cycles
  task automatic run_load(input logic [W-1:0] w0, w1, input int g0, g1,
                          input int rb_mode, hold, start_at, stop_at);
    int idx, gap;
    bit hs, last_seen, pulsed;
    r_shifts = 0; r_en_low = 0; r_rb_seen = 0; r_rel = -1;
    r_third = 0; r_done_ok = 0; r_timeout = 0; r_early = 0;
    rbq.delete();
    idx = 0; gap = g0; last_seen = 0; pulsed = 0;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_started_ok = busy && !done;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (last_seen) begin
        r_done_ok = done && !busy;
        break;
      end
      if (r_shifts == stop_at) begin
        in_valid = 1'b0;
        return;
      end
      start = 1'b0;
      if (r_shifts == start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end
      case (rb_mode)
        0: rb_ready = 1'b1;
        1: rb_ready = 1'($urandom_range(0, 1));
        default: rb_ready = (cyc >= hold);
      endcase
      if (rb_mode == 2 && cyc == hold) r_rel = r_shifts;
      in_valid = (idx < 2 && gap == 0);
      in_data = (idx == 0) ? w0 : w1;
      #1;
      if (in_ready && idx >= 2) r_third = 1;
      if (rb_valid) r_rb_seen++;
      if (rb_valid && rb_ready) rbq.push_back(rb_data);
      if (done) r_early = 1;
      hs = in_valid && in_ready;
      if (in_ready && !in_valid && idx < 2 && gap > 0) gap--;
      if (chain_clk_en) begin
        r_shifts++;
        if (r_shifts == L) last_seen = 1;
      end else if (busy) begin
        r_en_low++;
      end
      @(negedge clk);
      if (hs) begin
        idx++;
        gap = g1;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    r_timeout = !last_seen;
    rb_ready = 1'b1;
    repeat (3) begin
      #1;
      if (rb_valid) rbq.push_back(rb_data);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, in_ready, chain_in, chain_clk_en, rb_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 000000",
               {busy, done, in_ready, chain_in, chain_clk_en, rb_valid});
    end
    tests++;
    if (rb_data !== '0) begin
      fails++;
      $display("FAIL reset_rb_data got %h want 0", rb_data);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, in_ready} !== 3'b0) begin
      fails++;
      $display("FAIL idle_after_reset got %b want 000", {busy, done, in_ready});
    end
  endtask

  task automatic check_load(input string nm, input logic [L-1:0] exp, input int exp_low);
    tests++;
    if (r_timeout || r_early) begin
      fails++;
      $display("FAIL %s_finish timeout=%0b early_done=%0b want 0/0", nm, r_timeout, r_early);
    end
    tests++;
    if (r_shifts !== L) begin
      fails++;
      $display("FAIL %s_shifts got %0d want %0d", nm, r_shifts, L);
    end
    tests++;
    if (chain !== exp) begin
      fails++;
      $display("FAIL %s_image got %h want %h", nm, chain, exp);
    end
    tests++;
    if (!r_done_ok || !r_started_ok) begin
      fails++;
      $display("FAIL %s_handshake done_ok=%0b started_ok=%0b want 1/1", nm, r_done_ok, r_started_ok);
    end
    tests++;
    if (r_third) begin
      fails++;
      $display("FAIL %s_extra_word in_ready high after last word got 1 want 0", nm);
    end
    if (exp_low >= 0) begin
      tests++;
      if (r_en_low !== exp_low) begin
        fails++;
        $display("FAIL %s_idle_cycles got %0d want %0d", nm, r_en_low, exp_low);
      end
    end
  endtask

  task automatic check_rb(input string nm, input logic [L-1:0] prev);
    logic [2*W-1:0] p;
    p = {{(2*W-L){1'b0}}, prev};
    tests++;
    if (rbq.size() != 2) begin
      fails++;
      $display("FAIL %s_rb_count got %0d want 2", nm, rbq.size());
    end else begin
      tests++;
      if (rbq[0] !== p[W-1:0] || rbq[1] !== p[2*W-1:W]) begin
        fails++;
        $display("FAIL %s_rb_words got %h %h want %h %h",
                 nm, rbq[0], rbq[1], p[W-1:0], p[2*W-1:W]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] exp;
    exp = image_of(32'hDEADBEEF, 32'h000000A5);
    run_load(32'hDEADBEEF, 32'h000000A5, 0, 0, 0, 0, -1, -1);
    check_load("b2b", exp, 1);
    tests++;
    if (chain[0] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_last_cell got %b want 1", chain[0]);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_sticky got done=%b busy=%b want 1/0", done, busy);
    end
    ref_img = exp;
    ref_known = 1;
  endtask

  task automatic test_gap();
    logic [L-1:0] exp;
    exp = image_of(32'hDEADBEEF, 32'h000000A5);
    run_load(32'hDEADBEEF, 32'h000000A5, 0, 5, 0, 0, -1, -1);
    check_load("gap", exp, 1 + 5);
    ref_img = exp;
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    run_load(a, b, 0, 0, 0, 0, 10, -1);
    check_load("start_in_load", image_of(a, b), 1);
    ref_img = image_of(a, b);
  endtask

  task automatic test_reset_mid_load();
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    run_load(a, b, 0, 0, 0, 0, -1, 17);
    tests++;
    if (r_shifts !== 17) begin
      fails++;
      $display("FAIL abort_point got %0d want 17", r_shifts);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, in_ready, chain_in, chain_clk_en, rb_valid} !== 6'b0 || rb_data !== '0) begin
      fails++;
      $display("FAIL abort_outputs got %b rb=%h want 000000 rb=0",
               {busy, done, in_ready, chain_in, chain_clk_en, rb_valid}, rb_data);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_known = 0;
    a = $urandom;
    b = $urandom;
    run_load(a, b, 0, 0, 0, 0, -1, -1);
    check_load("reload", image_of(a, b), 1);
    ref_img = image_of(a, b);
    ref_known = 1;
  endtask

`ifdef CONFIG_READBACK_EN
  task automatic test_readback();
    run_load(32'hDEADBEEF, 32'h000000A5, 0, 0, 0, 0, -1, -1);
    check_load("rb_fill", image_of(32'hDEADBEEF, 32'h000000A5), 1);
    run_load('0, '0, 0, 0, 0, 0, -1, -1);
    check_load("rb_zero", '0, 1);
    tests++;
    if (rbq.size() != 2) begin
      fails++;
      $display("FAIL rb_known_count got %0d want 2", rbq.size());
    end else begin
      tests++;
      if (rbq[0] !== 32'hDEADBEEF || rbq[1] !== 32'h000000A5) begin
        fails++;
        $display("FAIL rb_known_words got %h %h want deadbeef 000000a5", rbq[0], rbq[1]);
      end
    end
    ref_img = '0;
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    logic [L-1:0] prev;
    int stop;
    a = $urandom;
    b = $urandom;
    run_load(a, b, 0, 0, 0, 0, -1, -1);
    prev = image_of(a, b);
    stop = (2 * W - 1 < L - 1) ? 2 * W - 1 : L - 1;
    run_load($urandom, $urandom, 0, 0, 2, 80, -1, -1);
    tests++;
    if (r_rel !== stop) begin
      fails++;
      $display("FAIL stall_point got %0d want %0d", r_rel, stop);
    end
    tests++;
    if (r_timeout || r_shifts !== L || !r_done_ok) begin
      fails++;
      $display("FAIL stall_resume shifts=%0d timeout=%0b done_ok=%0b want %0d/0/1",
               r_shifts, r_timeout, r_done_ok, L);
    end
    check_rb("stall", prev);
    ref_img = chain;
  endtask
`else
  task automatic test_no_readback();
    run_load($urandom, $urandom, 0, 0, 1, 0, -1, -1);
    tests++;
    if (r_rb_seen !== 0 || rb_data !== '0) begin
      fails++;
      $display("FAIL no_rb got valid_cycles=%0d data=%h want 0/0", r_rb_seen, rb_data);
    end
    ref_img = chain;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [L-1:0] exp;
    int g0, g1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      g0 = $urandom_range(0, 3);
      g1 = $urandom_range(0, 4);
      exp = image_of(a, b);
`ifdef CONFIG_READBACK_EN
      run_load(a, b, g0, g1, 1, 0, -1, -1);
      check_load("rand", exp, -1);
      if (ref_known) check_rb("rand", ref_img);
`else
      run_load(a, b, g0, g1, 0, 0, -1, -1);
      check_load("rand", exp, 1 + g0 + g1);
`endif
      ref_img = exp;
      ref_known = 1;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_start_ignored();
    test_reset_mid_load();
`ifdef CONFIG_READBACK_EN
    test_readback();
    test_stall();
`else
    test_no_readback();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
